cond_dechain: RTL and testbench
===============================

Name: cond_dechain

Overview:
- Receive-side inverse of the cond XOR-scrambling chain (stage masks A..D, applied in order 0..3 on the transmit side).
- Takes scrambled words and removes each enabled stage's mask in reverse order (D, C, B, A), one registered pipeline stage per mask.
- Uses a valid/ready handshake for backpressure and counts the words it delivers.
- Sits at the far end of the data path, after the cond chain, and restores the original data.

Parameters:
- PAR_DATA_BITS, 16, data word width.
- PAR_STAGE_EN, 4'b1111, bit i set = transmit-side stage i was instantiated and must be undone; bit 0 = A ... bit 3 = D.
- PAR_XOR_A, 16'h0F0F, stage 0 mask, truncated/zero-extended to PAR_DATA_BITS.
- PAR_XOR_B, 16'hF0F0, stage 1 mask.
- PAR_XOR_C, 16'h0F0F, stage 2 mask.
- PAR_XOR_D, 16'h0F0F, stage 3 mask.

Ports:
- ib_clk  in  1  clock, all logic on rising edge.
- ib_rst  in  1  asynchronous reset, active-low: assert async, deassert synchronised externally.
- ib_clear  in  1  synchronous flush of pipeline and counter.
- ivG_data  in  PAR_DATA_BITS  scrambled input word.
- ib_valid  in  1  ivG_data valid.
- ob_ready  out  1  block can accept ivG_data this cycle.
- ovG_data  out  PAR_DATA_BITS  descrambled output word.
- ob_valid  out  1  ovG_data valid.
- ib_ready  in  1  downstream accepts ovG_data.
- ovG_count  out  16  words delivered since reset/clear, saturating.
- ob_busy  out  1  any pipeline stage holds a word.

Behaviour:
- Reset (ib_rst low): all stage valid bits 0, stage data 0, ovG_data 0, ob_valid 0, ovG_count 0, ob_busy 0. ob_ready reads 1 after reset unless ib_clear is high.
- Pipeline: 4 register stages S1..S4, each holding a valid bit and a data word.
  - S1 loads ivG_data ^ (D if EN[3]).
  - S2 loads S1 ^ (C if EN[2]).
  - S3 loads S2 ^ (B if EN[1]).
  - S4 loads S3 ^ (A if EN[0]).
  - A disabled stage still registers with no XOR, so latency is a constant 4 cycles regardless of PAR_STAGE_EN.
- Outputs: ovG_data = S4 data; ob_valid = S4 valid.
- Advance rules:
  - adv4 = ib_ready.
  - Stage n (n<4) may load when !valid(n+1) or adv(n+1).
  - ob_ready = !valid(S1) or S1 may load, and is forced to 0 when ib_clear = 1.
- Transfers: an input transfer occurs when ib_valid & ob_ready. An output transfer occurs when ob_valid & ib_ready.
- Throughput: 1 word/cycle sustained with ib_ready = 1. With ib_ready = 0, the pipeline fills to 4 words and ob_ready drops in the cycle the 4th word is held.
- Ready-chain timing: the ready chain is combinational from ib_ready to ob_ready (no skid buffer). Zero-bubble: when full and ib_ready = 1, a new input is accepted in the same cycle.
- Data hold: stage data and ovG_data hold while stalled. ovG_data must not change while ob_valid & !ib_ready.
- Counter: ovG_count increments by 1 on each output transfer and saturates at 16'hFFFF (no wrap).
- ob_busy = OR of S1..S4 valid bits.
- ib_clear = 1:
  - Next edge: all valid bits 0 and ovG_count 0; stage data unchanged.
  - Input offered that cycle is not accepted (ob_ready = 0).
  - An output transfer in the clear cycle is not counted.
- Simultaneous input and output transfer when full: the pipeline shifts, occupancy unchanged, count +1.
- Reset mid-operation: in-flight words are discarded immediately; no partial outputs.

Test Plan:
- Reset with ib_valid = 1 and ivG_data = 16'hAAAA held -> ob_valid = 0, ovG_data = 0, ovG_count = 0, ob_busy = 0 throughout reset; ob_ready = 1 after release.
- Decode check, each config run with masks A..D at defaults and input 16'h1234:
  - PAR_STAGE_EN = 4'b0011 -> ovG_data 16'hEDCB.
  - PAR_STAGE_EN = 4'b0101 -> 16'h1234.
  - PAR_STAGE_EN = 4'b1111 -> 16'hEDCB.
  - PAR_STAGE_EN = 4'b0000 -> 16'h1234.
  - In every case ob_valid rises exactly 4 cycles after the input transfer.
- Streaming: 100 back-to-back words 0..99 with ib_ready = 1 -> one output per cycle, order preserved, no bubbles, ovG_count = 100.
- Backpressure: ib_ready = 0, offer 5 words -> exactly 4 accepted, ob_ready = 0 after the 4th. Raise ib_ready -> 5th accepted same cycle, outputs in order, ovG_data stable while stalled, ovG_count = 5.
- Clear and reset mid-flight: 3 words in flight, pulse ib_clear 1 cycle -> ob_busy = 0 next cycle, ovG_count = 0, no stale outputs appear. Repeat with ib_rst low asynchronously between edges -> outputs go to 0 immediately.
- Saturation: 65 540 output transfers -> ovG_count reaches 16'hFFFF and holds; ib_clear returns it to 0.

Source files
------------

// File: rtl/cond_dechain.sv
// cond_dechain: strips the cond XOR-scrambling chain (masks D, C, B, A in that order)
// through a fixed 4-stage valid/ready pipeline and counts delivered words
module cond_dechain #(
  parameter int          PAR_DATA_BITS = 16,
  parameter logic [3:0]  PAR_STAGE_EN  = 4'b1111,
  parameter logic [15:0] PAR_XOR_A     = 16'h0F0F,
  parameter logic [15:0] PAR_XOR_B     = 16'hF0F0,
  parameter logic [15:0] PAR_XOR_C     = 16'h0F0F,
  parameter logic [15:0] PAR_XOR_D     = 16'h0F0F
) (
  input  logic                     ib_clk,
  input  logic                     ib_rst,
  input  logic                     ib_clear,
  input  logic [PAR_DATA_BITS-1:0] ivG_data,
  input  logic                     ib_valid,
  output logic                     ob_ready,
  output logic [PAR_DATA_BITS-1:0] ovG_data,
  output logic                     ob_valid,
  input  logic                     ib_ready,
  output logic [15:0]              ovG_count,
  output logic                     ob_busy
);
  localparam int W = PAR_DATA_BITS;
  // Stage 0 (S1) undoes D, stage 3 (S4) undoes A; a disabled stage passes data through
  localparam logic [3:0][W-1:0] MSK = {
    {W{PAR_STAGE_EN[0]}} & W'(PAR_XOR_A),
    {W{PAR_STAGE_EN[1]}} & W'(PAR_XOR_B),
    {W{PAR_STAGE_EN[2]}} & W'(PAR_XOR_C),
    {W{PAR_STAGE_EN[3]}} & W'(PAR_XOR_D)
  };
  logic [3:0]        vld, in_v, ld;
  logic [3:0][W-1:0] dat, in_d;
  logic              ld1, ld2, ld3, ld4;
  // Combinational ready chain from the sink back to the source; no skid buffering
  assign ld4 = !vld[3] | ib_ready;
  assign ld3 = !vld[2] | ld4;
  assign ld2 = !vld[1] | ld3;
  assign ld1 = !vld[0] | ld2;
  assign ld  = {ld4, ld3, ld2, ld1};
  assign ob_ready = ld1 & !ib_clear;
  assign in_v = {vld[2:0], ib_valid & ob_ready};
  assign in_d = {dat[2:0], ivG_data};
  assign ovG_data = dat[3];
  assign ob_valid = vld[3];
  assign ob_busy  = |vld;
  always_ff @(posedge ib_clk or negedge ib_rst) begin
    if (!ib_rst) begin
      vld       <= '0;
      dat       <= '0;
      ovG_count <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        vld[i] <= ib_clear ? 1'b0 : ld[i] ? in_v[i] : vld[i];
        if (!ib_clear && ld[i] && in_v[i]) dat[i] <= in_d[i] ^ MSK[i];
      end
      ovG_count <= ib_clear ? '0 : (ob_valid && ib_ready && !(&ovG_count)) ? ovG_count + 16'd1 : ovG_count;
    end
  end
endmodule

// File: tb/tb_cond_dechain.sv
// tb_cond_dechain: four stage-enable configurations driven in lockstep and checked against
// a queue-of-words model in which each word carries its pipeline position
module tb_cond_dechain;
  localparam logic [3:0] ENS [4] = '{4'b1111, 4'b0011, 4'b0101, 4'b0000};
  logic        ib_clk = 0, ib_rst = 1, ib_clear = 0, ib_valid = 0, ib_ready = 0;
  logic [15:0] ivG_data = '0;
  logic [15:0] o_data [4];
  logic [15:0] o_count [4];
  logic        o_valid [4];
  logic        o_ready [4];
  logic        o_busy [4];
  int          errors = 0, checks = 0;
  logic [15:0] qd [$];
  int          qp [$];
  int          m_cnt = 0, prev, np;
  bit          acc;
  always #5 ib_clk = ~ib_clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    cond_dechain #(.PAR_STAGE_EN(ENS[g])) dut (
      .ib_clk(ib_clk), .ib_rst(ib_rst), .ib_clear(ib_clear),
      .ivG_data(ivG_data), .ib_valid(ib_valid), .ob_ready(o_ready[g]),
      .ovG_data(o_data[g]), .ob_valid(o_valid[g]), .ib_ready(ib_ready),
      .ovG_count(o_count[g]), .ob_busy(o_busy[g])
    );
  end
  function automatic logic [15:0] mask_of(input logic [3:0] en);
    return (en[0] ? 16'h0F0F : 16'h0) ^ (en[1] ? 16'hF0F0 : 16'h0)
         ^ (en[2] ? 16'h0F0F : 16'h0) ^ (en[3] ? 16'h0F0F : 16'h0);
  endfunction
  function automatic bit m_out();
    return qd.size() > 0 && qp[0] == 4;
  endfunction
  // A word moves one position per edge unless the word ahead of it blocks; entry needs position 1 free
  function automatic bit m_ready();
    int p = 5;
    int n;
    if (ib_clear) return 0;
    for (int i = (m_out() && ib_ready) ? 1 : 0; i < qp.size(); i++) begin
      n = qp[i] + 1;
      if (n > 4) n = 4;
      if (n > p - 1) n = p - 1;
      p = n;
    end
    return p >= 2;
  endfunction
  task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", n, k, act, exp, $time);
    end
  endtask
  always @(posedge ib_clk or negedge ib_rst) begin
    if (!ib_rst || ib_clear) begin
      qd.delete();
      qp.delete();
      m_cnt = 0;
    end else begin
      acc = ib_valid && m_ready();
      if (m_out() && ib_ready) begin
        void'(qd.pop_front());
        void'(qp.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      prev = 5;
      for (int i = 0; i < qp.size(); i++) begin
        np = qp[i] + 1;
        if (np > 4) np = 4;
        if (np > prev - 1) np = prev - 1;
        qp[i] = np;
        prev = np;
      end
      if (acc) begin
        qd.push_back(ivG_data);
        qp.push_back(1);
      end
    end
  end
  always @(negedge ib_clk) begin
    for (int k = 0; k < 4; k++) begin
      chk("valid", k, 32'(o_valid[k]), 32'(m_out()));
      chk("ready", k, 32'(o_ready[k]), 32'(m_ready()));
      chk("busy", k, 32'(o_busy[k]), 32'(qd.size() > 0));
      chk("count", k, 32'(o_count[k]), 32'(m_cnt));
      if (m_out()) chk("data", k, 32'(o_data[k]), 32'(qd[0] ^ mask_of(ENS[k])));
    end
  end
  task automatic step();
    @(posedge ib_clk);
    #1;
  endtask
  task automatic pulse_clear();
    ib_valid = 0;
    ib_clear = 1;
    step();
    ib_clear = 0;
  endtask
  initial begin
    logic [15:0] dec [4];
    dec = '{16'hEDCB, 16'hEDCB, 16'h1234, 16'h1234};
    #1;
    ib_rst = 0;
    ib_valid = 1;
    ivG_data = 16'hAAAA;
    ib_ready = 1;
    repeat (3) begin
      step();
      for (int k = 0; k < 4; k++) begin
        chk("rst_valid", k, 32'(o_valid[k]), 0);
        chk("rst_data", k, 32'(o_data[k]), 0);
        chk("rst_count", k, 32'(o_count[k]), 0);
        chk("rst_busy", k, 32'(o_busy[k]), 0);
      end
    end
    ib_valid = 0;
    ib_rst = 1;
    step();
    chk("rel_ready", 0, 32'(o_ready[0]), 1);
    ib_valid = 1;
    ivG_data = 16'h1234;
    step();
    ib_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk("latency_early", c, 32'(o_valid[0]), 0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk("latency4", k, 32'(o_valid[k]), 1);
      chk("decode", k, 32'(o_data[k]), 32'(dec[k]));
    end
    step();
    pulse_clear();
    for (int i = 0; i < 100; i++) begin
      ib_valid = 1;
      ivG_data = 16'(i);
      step();
    end
    ib_valid = 0;
    repeat (4) step();
    chk("stream_count", 0, 32'(o_count[0]), 100);
    pulse_clear();
    ib_ready = 0;
    ib_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ivG_data = 16'h0100 + 16'(i);
      step();
    end
    ivG_data = 16'h0104;
    chk("bp_full_ready", 0, 32'(o_ready[0]), 0);
    chk("bp_head", 0, 32'(o_data[0]), 32'h0000FEFF);
    step();
    chk("bp_hold_ready", 0, 32'(o_ready[0]), 0);
    chk("bp_hold_data", 0, 32'(o_data[0]), 32'h0000FEFF);
    ib_ready = 1;
    #1;
    chk("bp_zero_bubble", 0, 32'(o_ready[0]), 1);
    step();
    ib_valid = 0;
    repeat (5) step();
    chk("bp_count", 0, 32'(o_count[0]), 5);
    for (int i = 0; i < 3; i++) begin
      ib_valid = 1;
      ivG_data = 16'h0200 + 16'(i);
      step();
    end
    pulse_clear();
    chk("clr_busy", 0, 32'(o_busy[0]), 0);
    chk("clr_count", 0, 32'(o_count[0]), 0);
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      ib_valid = 1;
      ivG_data = 16'h0300 + 16'(i);
      step();
    end
    ib_valid = 0;
    chk("pre_rst_valid", 0, 32'(o_valid[0]), 1);
    #2;
    ib_rst = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("async_valid", k, 32'(o_valid[k]), 0);
      chk("async_data", k, 32'(o_data[k]), 0);
      chk("async_busy", k, 32'(o_busy[k]), 0);
    end
    step();
    ib_rst = 1;
    step();
    for (int c = 0; c < 3000; c++) begin
      ib_valid = ($urandom % 4) != 0;
      ib_ready = ($urandom % 3) != 0;
      ib_clear = ($urandom % 40) == 0;
      ivG_data = 16'($urandom);
      step();
    end
    pulse_clear();
    ib_valid = 1;
    ib_ready = 1;
    for (int c = 0; c < 65540; c++) begin
      ivG_data = 16'($urandom);
      step();
    end
    chk("sat_count", 0, 32'(o_count[0]), 32'h0000FFFF);
    repeat (3) step();
    chk("sat_hold", 0, 32'(o_count[0]), 32'h0000FFFF);
    pulse_clear();
    chk("sat_clear", 0, 32'(o_count[0]), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
